// File: rtl/wb_retire_buffer.sv
// Write-back retire buffer: aligns sub-word loads at push, queues retiring instructions,
// drains one per cycle to a registered register-file write port and serves operand forwarding.
module wb_retire_buffer #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 4,
  parameter int DROP_R0      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_LEN-1:0]   in_rd,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_wr,
  input  logic [1:0]                in_wmode,
  input  logic                      in_sext,
  input  logic [1:0]                in_off,
  input  logic                      in_halt,
  input  logic                      wb_stall,
  output logic [REG_ADDR_LEN-1:0]   wb_addr,
  output logic [WIDTH-1:0]          wb_data,
  output logic                      wb_wr_en,
  output logic [1:0]                wb_mode,
  output logic                      halt,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [REG_ADDR_LEN-1:0]   fwd_addr,
  output logic                      fwd_hit,
  output logic [WIDTH-1:0]          fwd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_ADDR_LEN-1:0] q_rd   [DEPTH];
  logic [WIDTH-1:0]        q_data [DEPTH];
  logic [1:0]              q_mode [DEPTH];
  logic                    q_eff  [DEPTH];
  logic                    q_halt [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr, fwd_idx;
  logic             halt_pending, full, push, pop, push_eff;
  logic [15:0]      half_f;
  logic [7:0]       byte_f;
  logic [WIDTH-1:0] push_data;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !halt_pending && !halt;
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !wb_stall;
  // Write effect is resolved once at push so pop and forwarding share the same rule.
  assign push_eff = in_wr && !((DROP_R0 != 0) && (in_rd == '0)) && !in_halt;

  always_comb begin
    half_f    = in_data[{in_off[1], 4'b0000} +: 16];
    byte_f    = in_data[{in_off, 3'b000} +: 8];
    push_data = in_data;
    case (in_wmode)
      2'd1:    push_data = {{(WIDTH-16){in_sext & half_f[15]}}, half_f};
      2'd2:    push_data = {{(WIDTH-8){in_sext & byte_f[7]}}, byte_f};
      default: push_data = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= in_rd;
      q_data[wr_ptr] <= push_data;
      q_mode[wr_ptr] <= in_wmode;
      q_eff[wr_ptr]  <= push_eff;
      q_halt[wr_ptr] <= in_halt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt         <= 1'b0;
      halt_pending <= 1'b0;
      wb_wr_en     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wb_mode      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (in_halt) halt_pending <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wb_wr_en <= 1'b0;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        wb_addr  <= q_rd[rd_ptr];
        wb_data  <= q_data[rd_ptr];
        wb_mode  <= q_mode[rd_ptr];
        wb_wr_en <= q_eff[rd_ptr];
        if (q_halt[rd_ptr]) halt <= 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; wb_* is the oldest candidate.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (wb_wr_en && (wb_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && q_eff[fwd_idx] && (q_rd[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[fwd_idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed self-checking bench for wb_retire_buffer: reset, alignment, fill/stall,
// forwarding, r0 drop and halt ordering.
module tb_wb_retire_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wr, in_sext, in_halt, wb_stall;
  logic [4:0]  in_rd, wb_addr, fwd_addr;
  logic [31:0] in_data, wb_data, fwd_data;
  logic [1:0]  in_wmode, in_off, wb_mode;
  logic        wb_wr_en, halt, fwd_hit;
  logic [2:0]  count;

  int total  = 0;
  int passed = 0;

  wb_retire_buffer #(.WIDTH(32), .REG_ADDR_LEN(5), .DEPTH(4), .DROP_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .in_wr(in_wr), .in_wmode(in_wmode), .in_sext(in_sext), .in_off(in_off),
    .in_halt(in_halt), .wb_stall(wb_stall), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_wr_en(wb_wr_en), .wb_mode(wb_mode), .halt(halt), .count(count),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic wr,
                      input logic [1:0] mode, input logic sext, input logic [1:0] off,
                      input logic h);
    in_valid = 1'b1; in_rd = rd; in_data = d; in_wr = wr;
    in_wmode = mode; in_sext = sext; in_off = off; in_halt = h;
    step();
    in_valid = 1'b0; in_halt = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (wb_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wb_wr_en); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else passed++;
    total++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt); else passed++;
    total++; if ({wb_addr, wb_data, wb_mode} !== 39'd0) $display("FAIL reset_wb_regs: got %h expected 0", {wb_addr, wb_data, wb_mode}); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_queue();
    int writes = 0;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(5'(i + 1), 32'(i + 10), 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    total++; if (count !== 3'd3) $display("FAIL midq_count_before: got %0d expected 3", count); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0) $display("FAIL midq_count: got %0d expected 0", count); else passed++;
    total++; if (wb_wr_en !== 1'b0) $display("FAIL midq_wr_en: got %b expected 0", wb_wr_en); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL midq_ready: got %b expected 1", in_ready); else passed++;
    rst_n = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_wr_en) writes++;
    end
    total++; if (writes !== 0) $display("FAIL midq_no_write: got %0d writes expected 0", writes); else passed++;
  endtask

  task automatic test_subword();
    logic [1:0]  modes [5] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic        sexts [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  offs  [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] exps  [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080F1, 32'hFFFF80F1, 32'h80F17F02};
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(5'd9, 32'h80F17F02, 1'b1, modes[i], sexts[i], offs[i], 1'b0);
      step();
      total++; if (wb_wr_en !== 1'b1 || wb_data !== exps[i] || wb_addr !== 5'd9 || wb_mode !== modes[i])
        $display("FAIL subword_%0d: got en=%b addr=%0d data=%h mode=%0d expected en=1 addr=9 data=%h mode=%0d",
                 i, wb_wr_en, wb_addr, wb_data, wb_mode, exps[i], modes[i]);
      else passed++;
    end
    step();
    total++; if (wb_wr_en !== 1'b0 || wb_data !== 32'h80F17F02) $display("FAIL subword_idle_hold: got en=%b data=%h expected en=0 data=80f17f02", wb_wr_en, wb_data); else passed++;
  endtask

  task automatic test_fill_stall();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(i + 1), 32'(100 + i), 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    total++; if (count !== 3'd4 || in_ready !== 1'b0) $display("FAIL fill_full: got count=%0d ready=%b expected count=4 ready=0", count, in_ready); else passed++;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (wb_wr_en !== 1'b1 || wb_addr !== 5'(i + 1) || wb_data !== 32'(100 + i) || count !== 3'(3 - i) || in_ready !== 1'b1)
        $display("FAIL drain_%0d: got en=%b addr=%0d data=%0d count=%0d ready=%b expected en=1 addr=%0d data=%0d count=%0d ready=1",
                 i, wb_wr_en, wb_addr, wb_data, count, in_ready, i + 1, 100 + i, 3 - i);
      else passed++;
    end
    step();
    total++; if (wb_wr_en !== 1'b0) $display("FAIL drain_end: got en=%b expected 0", wb_wr_en); else passed++;
  endtask

  task automatic test_forwarding();
    wb_stall = 1'b1;
    push(5'd5, 32'd11, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    push(5'd5, 32'd22, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    push(5'd0, 32'd33, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    fwd_addr = 5'd5; #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd22) $display("FAIL fwd_youngest: got hit=%b data=%0d expected hit=1 data=22", fwd_hit, fwd_data); else passed++;
    fwd_addr = 5'd0; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) $display("FAIL fwd_r0: got hit=%b data=%0d expected hit=0 data=0", fwd_hit, fwd_data); else passed++;
    fwd_addr = 5'd7; #1;
    total++; if (fwd_hit !== 1'b0) $display("FAIL fwd_miss: got hit=%b expected 0", fwd_hit); else passed++;
    fwd_addr = 5'd5;
    wb_stall = 1'b0;
    step();
    step();
    total++; if (wb_wr_en !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== 32'd22) $display("FAIL fwd_wb_reg: got en=%b hit=%b data=%0d expected en=1 hit=1 data=22", wb_wr_en, fwd_hit, fwd_data); else passed++;
    step();
    total++; if (wb_wr_en !== 1'b0 || fwd_hit !== 1'b0) $display("FAIL fwd_after_r0: got en=%b hit=%b expected en=0 hit=0", wb_wr_en, fwd_hit); else passed++;
  endtask

  task automatic test_r0_drop();
    wb_stall = 1'b0;
    push(5'd0, 32'h55, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    total++; if (count !== 3'd1) $display("FAIL r0_count_push: got %0d expected 1", count); else passed++;
    step();
    total++; if (count !== 3'd0 || wb_wr_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'h55)
      $display("FAIL r0_drop: got count=%0d en=%b addr=%0d data=%h expected count=0 en=0 addr=0 data=55", count, wb_wr_en, wb_addr, wb_data);
    else passed++;
    push(5'd3, 32'h66, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    step();
    total++; if (wb_wr_en !== 1'b0 || wb_addr !== 5'd3) $display("FAIL nowr: got en=%b addr=%0d expected en=0 addr=3", wb_wr_en, wb_addr); else passed++;
  endtask

  task automatic test_halt();
    wb_stall = 1'b1;
    push(5'd1, 32'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    push(5'd4, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    total++; if (in_ready !== 1'b0 || count !== 3'd2) $display("FAIL halt_block: got ready=%b count=%0d expected ready=0 count=2", in_ready, count); else passed++;
    push(5'd2, 32'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    total++; if (count !== 3'd2) $display("FAIL halt_refuse: got count=%0d expected 2", count); else passed++;
    wb_stall = 1'b0;
    step();
    total++; if (wb_wr_en !== 1'b1 || wb_addr !== 5'd1 || halt !== 1'b0) $display("FAIL halt_r1: got en=%b addr=%0d halt=%b expected en=1 addr=1 halt=0", wb_wr_en, wb_addr, halt); else passed++;
    step();
    total++; if (halt !== 1'b1 || wb_wr_en !== 1'b0 || count !== 3'd0) $display("FAIL halt_pop: got halt=%b en=%b count=%0d expected halt=1 en=0 count=0", halt, wb_wr_en, count); else passed++;
    for (int i = 0; i < 3; i++) step();
    total++; if (halt !== 1'b1 || wb_wr_en !== 1'b0 || in_ready !== 1'b0) $display("FAIL halt_sticky: got halt=%b en=%b ready=%b expected halt=1 en=0 ready=0", halt, wb_wr_en, in_ready); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; in_wr = 1'b0; in_wmode = '0;
    in_sext = 1'b0; in_off = '0; in_halt = 1'b0; wb_stall = 1'b0; fwd_addr = '0;
    #3;
    test_reset();
    test_reset_mid_queue();
    test_subword();
    test_fill_stall();
    test_forwarding();
    test_r0_drop();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
